// File: rtl/iterative_compare_pkg.sv
// Shared types and result decode for the multi-cycle relational comparator.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_LT   = 3'd0,
        OP_LE   = 3'd1,
        OP_GT   = 3'd2,
        OP_GE   = 3'd3,
        OP_EQ   = 3'd4,
        OP_NE   = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    function automatic logic cmp_resolve(cmp_op_e op, logic lt, logic gt, logic eq);
        logic flag;
        flag = 1'b0;
        unique case (op)
            OP_LT:   flag = lt;
            OP_LE:   flag = lt | eq;
            OP_GT:   flag = gt;
            OP_GE:   flag = gt | eq;
            OP_EQ:   flag = eq;
            OP_NE:   flag = ~eq;
            default: flag = 1'b0;
        endcase
        return flag;
    endfunction

endpackage

// File: rtl/iterative_compare_if.sv
// Issue-side and result-side handshake bundle for iterative_compare.
interface iterative_compare_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         is_signed;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         busy;

    modport master (
        output in_valid, a, b, is_signed, op, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, op, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/iterative_compare_chunk.sv
// Pure unsigned W-bit magnitude compare; equality is implied when neither flag is set.
module cmp_chunk #(
    parameter int W = 2
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o,
    output logic         gt_o
);
    assign lt_o = (a_i < b_i);
    assign gt_o = (a_i > b_i);
endmodule

// File: rtl/iterative_compare.sv
// Multi-cycle relational comparator, CHUNK bits per cycle from the MSB end.
// Define ITERATIVE_COMPARE_EARLY_EXIT_EN to stop at the first differing chunk.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SCAN  | comparing chunk idx, one chunk per cycle
// DONE  | result held until the consumer takes it
module iterative_compare
    import cmp_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    iterative_compare_if.slave cmp
);
    localparam int NCH  = N / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_chunk
        $error("iterative_compare: CHUNK must divide N and satisfy 1 <= CHUNK <= N");
    end

    cmp_state_e       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    cmp_op_e          op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             found_q, found_d;
    logic [N-1:0]     out_q, out_d;

    logic             c_lt, c_gt;
    logic             sel_lt, sel_gt;
    logic             last_chunk;

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .a_i  (a_q[int'(idx_q)*CHUNK +: CHUNK]),
        .b_i  (b_q[int'(idx_q)*CHUNK +: CHUNK]),
        .lt_o (c_lt),
        .gt_o (c_gt)
    );

    // The first difference seen wins; later chunks never overwrite it.
    assign sel_lt = found_q ? lt_q : c_lt;
    assign sel_gt = found_q ? gt_q : c_gt;

`ifdef ITERATIVE_COMPARE_EARLY_EXIT_EN
    assign last_chunk = (idx_q == '0) || c_lt || c_gt;
`else
    assign last_chunk = (idx_q == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_LT;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            found_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            found_q <= found_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        found_d = found_q;
        out_d   = out_q;

        unique case (state_q)
            IDLE: begin
                if (cmp.in_valid) begin
                    // Offset-binary: flipping both sign bits makes unsigned order match signed order.
                    a_d        = cmp.a;
                    b_d        = cmp.b;
                    a_d[N-1]   = cmp.a[N-1] ^ cmp.is_signed;
                    b_d[N-1]   = cmp.b[N-1] ^ cmp.is_signed;
                    op_d       = cmp_op_e'(cmp.op);
                    idx_d      = IDXW'(NCH - 1);
                    lt_d       = 1'b0;
                    gt_d       = 1'b0;
                    found_d    = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (!found_q && (c_lt || c_gt)) begin
                    found_d = 1'b1;
                    lt_d    = c_lt;
                    gt_d    = c_gt;
                end
                if (last_chunk) begin
                    out_d    = '0;
                    out_d[0] = cmp_resolve(op_q, sel_lt, sel_gt, !(sel_lt || sel_gt));
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (cmp.out_ready) begin
                    out_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmp.in_ready  = (state_q == IDLE);
    assign cmp.out_valid = (state_q == DONE);
    assign cmp.busy      = (state_q != IDLE);
    assign cmp.out       = out_q;

endmodule

// File: tb/tb_iterative_compare.sv
// Directed-vector bench for iterative_compare at N=8, CHUNK=2.
module tb_iterative_compare;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    iterative_compare_if #(.N(8)) cif ();

    iterative_compare #(.N(8), .CHUNK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (cif)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Chunks examined: first differing chunk from the MSB end, or all four if equal.
    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef ITERATIVE_COMPARE_EARLY_EXIT_EN
        for (int k = 3; k >= 0; k--)
            if (a[k*2 +: 2] != b[k*2 +: 2]) return 4 - k;
        return 4;
`else
        return 4;
`endif
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [2:0] op, input logic hold,
                          output logic [7:0] got, output int lat);
        cif.a         = a;
        cif.b         = b;
        cif.is_signed = s;
        cif.op        = op;
        cif.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        cif.in_valid  = 1'b0;
        cif.a         = ~a;
        cif.b         = 8'h00;
        cif.is_signed = ~s;
        cif.op        = 3'd4;
        lat = 0;
        while (!cif.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cif.out_valid) chk("result_timeout", 32'(cif.out_valid), 32'd1);
        got = cif.out;
        if (!hold) begin
            cif.out_ready = 1'b1;
            @(posedge clk);
            #1;
            cif.out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] got;
        int         lat;
        int         lat_rsv;
        int         lat_lt;

        vecs[0]  = '{8'h3C, 8'hC3, 1'b0, 3'd0, 8'h01};
        vecs[1]  = '{8'h80, 8'h7F, 1'b1, 3'd0, 8'h01};
        vecs[2]  = '{8'h80, 8'h7F, 1'b0, 3'd0, 8'h00};
        vecs[3]  = '{8'hFF, 8'hFE, 1'b1, 3'd3, 8'h01};
        vecs[4]  = '{8'hA5, 8'hA5, 1'b0, 3'd4, 8'h01};
        vecs[5]  = '{8'hA5, 8'hA5, 1'b0, 3'd5, 8'h00};
        vecs[6]  = '{8'hA5, 8'hA5, 1'b0, 3'd1, 8'h01};
        vecs[7]  = '{8'hA5, 8'hA5, 1'b0, 3'd2, 8'h00};
        vecs[8]  = '{8'h10, 8'h20, 1'b0, 3'd7, 8'h00};
        vecs[9]  = '{8'h10, 8'h20, 1'b0, 3'd0, 8'h01};
        vecs[10] = '{8'h01, 8'h02, 1'b0, 3'd0, 8'h01};
        vecs[11] = '{8'h7F, 8'h80, 1'b1, 3'd2, 8'h01};
        vecs[12] = '{8'h05, 8'h05, 1'b1, 3'd3, 8'h01};
        vecs[13] = '{8'hFF, 8'h01, 1'b1, 3'd0, 8'h01};
        vecs[14] = '{8'hFF, 8'h01, 1'b0, 3'd1, 8'h00};
        vecs[15] = '{8'h3C, 8'hC3, 1'b0, 3'd2, 8'h00};

        cif.in_valid  = 1'b0;
        cif.a         = '0;
        cif.b         = '0;
        cif.is_signed = 1'b0;
        cif.op        = '0;
        cif.out_ready = 1'b0;

        #12;
        chk("rst_in_ready",  32'(cif.in_ready),  32'd1);
        chk("rst_out_valid", 32'(cif.out_valid), 32'd0);
        chk("rst_out",       32'(cif.out),       32'd0);
        chk("rst_busy",      32'(cif.busy),      32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_rsv = -1;
        lat_lt  = -2;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("v%0d_in_ready", i), 32'(cif.in_ready), 32'd1);
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].op, 1'b0, got, lat);
            chk($sformatf("v%0d_out", i), 32'(got), 32'(vecs[i].exp));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].a, vecs[i].b)));
            chk($sformatf("v%0d_out_cleared", i), 32'(cif.out), 32'd0);
            if (i == 8) lat_rsv = lat;
            if (i == 9) lat_lt = lat;
        end
        chk("reserved_vs_lt_latency", 32'(lat_rsv), 32'(lat_lt));

        // Backpressure: result held, busy, and a new request ignored.
        run_op(8'h3C, 8'hC3, 1'b0, 3'd0, 1'b1, got, lat);
        chk("bp_first_out", 32'(got), 32'd1);
        cif.a        = 8'h00;
        cif.b        = 8'h00;
        cif.op       = 3'd4;
        cif.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out", c),       32'(cif.out),       32'd1);
            chk($sformatf("bp%0d_out_valid", c), 32'(cif.out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", c),  32'(cif.in_ready),  32'd0);
            chk($sformatf("bp%0d_busy", c),      32'(cif.busy),      32'd1);
        end
        cif.in_valid  = 1'b0;
        cif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cif.out_ready = 1'b0;
        chk("bp_rel_out_valid", 32'(cif.out_valid), 32'd0);
        chk("bp_rel_out",       32'(cif.out),       32'd0);
        chk("bp_rel_in_ready",  32'(cif.in_ready),  32'd1);
        chk("bp_rel_busy",      32'(cif.busy),      32'd0);

        // Reset pulse while scanning the second chunk.
        cif.a         = 8'h10;
        cif.b         = 8'h20;
        cif.is_signed = 1'b0;
        cif.op        = 3'd0;
        cif.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        cif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_scan_busy", 32'(cif.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(cif.out_valid), 32'd0);
        chk("rst_mid_out",       32'(cif.out),       32'd0);
        chk("rst_mid_busy",      32'(cif.busy),      32'd0);
        chk("rst_mid_in_ready",  32'(cif.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(8'h01, 8'h02, 1'b0, 3'd0, 1'b0, got, lat);
        chk("post_rst_out",     32'(got), 32'd1);
        chk("post_rst_latency", 32'(lat), 32'(exp_lat(8'h01, 8'h02)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
